// File: rtl/can_pkg.sv
// ---------------------------------------------------------------------------
// can_pkg
// Shared definitions for CAN error signalling:
//   - can_err_state_e : error-frame transmitter state encoding
//   - ERR_FLAG_BITS, ERR_DELIM_BITS, INTERMISSION_BITS : frame field lengths
// ---------------------------------------------------------------------------
package can_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    FLAG         = 3'd1,
    DELIM_WAIT   = 3'd2,
    DELIM        = 3'd3,
    INTERMISSION = 3'd4
  } can_err_state_e;

  localparam int ERR_FLAG_BITS     = 6;
  localparam int ERR_DELIM_BITS    = 8;
  localparam int INTERMISSION_BITS = 3;

endpackage

// File: rtl/can_error_frame_tx_if.sv
// ---------------------------------------------------------------------------
// can_error_frame_tx_if
// Signal bundle between the error monitors / bus, and the error-frame
// transmitter.
//   Erro_Req    : OR of the error monitor flags (level)
//   Bit_Entrada : bus readback, 0 = dominant
//   Bit_Saida   : TX drive, 0 = dominant, 1 = recessive/idle
//   Erro_Ativo  : error frame in progress
//   Erro_Fim    : one-clock pulse when the frame completes
//   Bus_Stuck   : sticky dominant-timeout flag
// Modports: master = monitor/bus side, slave = transmitter.
// ---------------------------------------------------------------------------
interface can_error_frame_tx_if;

  logic Erro_Req;
  logic Bit_Entrada;
  logic Bit_Saida;
  logic Erro_Ativo;
  logic Erro_Fim;
  logic Bus_Stuck;

  modport master (
    output Erro_Req,
    output Bit_Entrada,
    input  Bit_Saida,
    input  Erro_Ativo,
    input  Erro_Fim,
    input  Bus_Stuck
  );

  modport slave (
    input  Erro_Req,
    input  Bit_Entrada,
    output Bit_Saida,
    output Erro_Ativo,
    output Erro_Fim,
    output Bus_Stuck
  );

endinterface

// File: rtl/can_bit_timer.sv
// ---------------------------------------------------------------------------
// can_bit_timer
// Divides the system clock into CAN bit times. The counter runs
// 0..CLKS_PER_BIT-1 while run is high and is forced to 0 otherwise.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   run         : count enable; low holds the counter at 0
//   bit_start   : counter == 0
//   sample_pt   : counter == CLKS_PER_BIT/2
//   bit_prelast : counter == CLKS_PER_BIT-2 (one clock before bit end)
//   bit_last    : counter == CLKS_PER_BIT-1
// CLKS_PER_BIT must be >= 4 so that the four positions are distinct
// except that sample_pt and bit_prelast coincide at exactly 4.
// ---------------------------------------------------------------------------
module can_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_start,
  output logic sample_pt,
  output logic bit_prelast,
  output logic bit_last
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRELAST = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] CNT_SAMPLE  = CW'(CLKS_PER_BIT / 2);

  logic [CW-1:0] cnt_r;

  // Bit-time counter, wraps at the end of each bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (!run) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign bit_start   = (cnt_r == '0);
  assign sample_pt   = (cnt_r == CNT_SAMPLE);
  assign bit_prelast = (cnt_r == CNT_PRELAST);
  assign bit_last    = (cnt_r == CNT_LAST);

endmodule

// File: rtl/can_error_frame_tx.sv
// ---------------------------------------------------------------------------
// can_error_frame_tx
// Drives an active CAN error frame (6 dominant flag bits, then an 8-bit
// recessive delimiter) when the error monitors request it. After the flag
// the bus is read back: dominant bits from other nodes' superposed flags
// stretch the wait for the delimiter; too many of them raise Bus_Stuck.
// Ports:
//   Clock_TB : system clock (rising edge)
//   Reset    : synchronous, active-high
//   err_if   : can_error_frame_tx_if.slave (Erro_Req, Bit_Entrada in;
//              Bit_Saida, Erro_Ativo, Erro_Fim, Bus_Stuck out)
// Build option: CAN_INTERMISSION_EN adds 3 recessive intermission bits
// after the delimiter, with Erro_Fim moved to the end of intermission.
// ---------------------------------------------------------------------------
module can_error_frame_tx
  import can_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int MAX_DOM_BITS = 14
) (
  input logic            Clock_TB,
  input logic            Reset,
  can_error_frame_tx_if.slave err_if
);

  // One counter is reused for flag bits, dominant samples, delimiter bits
  // and intermission bits; it must hold MAX_DOM_BITS and ERR_DELIM_BITS.
  localparam int BCW = ($clog2(MAX_DOM_BITS + 1) > 4) ? $clog2(MAX_DOM_BITS + 1) : 4;

  can_err_state_e state_r, state_s;
  logic [BCW-1:0] bit_cnt_r, cnt_s, cnt_inc_s;
  logic           restart_r, restart_s;
  logic           stuck_r, stuck_s;
  logic           fim_r, fim_s;
  logic           saida_r, ativo_r;
  logic           run_s;
  logic           bit_start_s, sample_pt_s, bit_prelast_s, bit_last_s;

  // Timer only runs while the frame continues; leaving IDLE starts it at
  // count 0 so the first flag bit is a full bit time.
  assign run_s = (state_r != IDLE) && (state_s != IDLE);

  can_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk         (Clock_TB),
    .rst         (Reset),
    .run         (run_s),
    .bit_start   (bit_start_s),
    .sample_pt   (sample_pt_s),
    .bit_prelast (bit_prelast_s),
    .bit_last    (bit_last_s)
  );

  assign cnt_inc_s = bit_cnt_r + BCW'(1);

  // Next-state, counter and flag logic of the error-frame FSM.
  always_comb begin
    state_s   = state_r;
    cnt_s     = bit_cnt_r;
    restart_s = restart_r;
    stuck_s   = stuck_r;
    fim_s     = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s     = '0;
        restart_s = 1'b0;
        if (err_if.Erro_Req) begin
          state_s = FLAG;
        end else begin
          state_s = IDLE;
        end
      end
      FLAG: begin
        // Counted at bit start, so the count equals the bit being sent.
        if (bit_last_s && (bit_cnt_r == BCW'(ERR_FLAG_BITS))) begin
          state_s = DELIM_WAIT;
          cnt_s   = '0;
        end else if (bit_start_s) begin
          cnt_s = cnt_inc_s;
        end else begin
          cnt_s = bit_cnt_r;
        end
      end
      DELIM_WAIT: begin
        if (sample_pt_s) begin
          if (!err_if.Bit_Entrada) begin
            if (cnt_inc_s == BCW'(MAX_DOM_BITS)) begin
              state_s = IDLE;
              cnt_s   = '0;
              stuck_s = 1'b1;
            end else begin
              cnt_s = cnt_inc_s;
            end
          end else begin
            // The first recessive bit is already delimiter bit 1.
            state_s = DELIM;
            cnt_s   = BCW'(1);
          end
        end else begin
          cnt_s = bit_cnt_r;
        end
      end
      DELIM: begin
        if (sample_pt_s) begin
          if (!err_if.Bit_Entrada) begin
            restart_s = 1'b1;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end else if (bit_last_s) begin
          if (restart_r) begin
            // Restart lands on the next bit start.
            state_s   = FLAG;
            cnt_s     = '0;
            restart_s = 1'b0;
          end else if (bit_cnt_r == BCW'(ERR_DELIM_BITS)) begin
`ifdef CAN_INTERMISSION_EN
            state_s = INTERMISSION;
`else
            state_s = IDLE;
`endif
            cnt_s = '0;
          end else begin
            cnt_s = bit_cnt_r;
          end
        end else begin
          cnt_s = bit_cnt_r;
        end
      end
`ifdef CAN_INTERMISSION_EN
      INTERMISSION: begin
        // Readback is not looked at here.
        if (bit_last_s && (bit_cnt_r == BCW'(INTERMISSION_BITS))) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else if (bit_start_s) begin
          cnt_s = cnt_inc_s;
        end else begin
          cnt_s = bit_cnt_r;
        end
      end
`endif
      default: begin
        state_s   = IDLE;
        cnt_s     = '0;
        restart_s = 1'b0;
      end
    endcase

    // Erro_Fim is registered, so it is decided one clock before the last
    // clock of the final bit. At CLKS_PER_BIT=4 that clock is also the
    // sample point, hence the use of the updated delimiter count.
`ifdef CAN_INTERMISSION_EN
    if ((state_r == INTERMISSION) && bit_prelast_s && (bit_cnt_r == BCW'(INTERMISSION_BITS))) begin
      fim_s = 1'b1;
    end else begin
      fim_s = 1'b0;
    end
`else
    if ((state_r == DELIM) && bit_prelast_s && !restart_s && (cnt_s == BCW'(ERR_DELIM_BITS))) begin
      fim_s = 1'b1;
    end else begin
      fim_s = 1'b0;
    end
`endif
  end

  // State, counters and registered outputs.
  always_ff @(posedge Clock_TB) begin
    if (Reset) begin
      state_r   <= IDLE;
      bit_cnt_r <= '0;
      restart_r <= 1'b0;
      stuck_r   <= 1'b0;
      fim_r     <= 1'b0;
      saida_r   <= 1'b1;
      ativo_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= cnt_s;
      restart_r <= restart_s;
      stuck_r   <= stuck_s;
      fim_r     <= fim_s;
      saida_r   <= (state_s != FLAG);
      ativo_r   <= (state_s != IDLE);
    end
  end

  assign err_if.Bit_Saida  = saida_r;
  assign err_if.Erro_Ativo = ativo_r;
  assign err_if.Erro_Fim   = fim_r;
  assign err_if.Bus_Stuck  = stuck_r;

endmodule
